// File: rtl/bla_subtractor_seq.sv
// ----------------------------------------------------------------------------
// bla_subtractor_seq
//
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin (modulo 2^WIDTH).
// Each clock processes one 4-bit slice, starting with the LSB slice. Inside a
// slice the borrows come from a flat borrow-lookahead expansion. The borrow out
// of each slice is registered and feeds the next slice. This block is the
// inverse-operation companion to the carry-lookahead adder.
//
// Handshake: operands are taken on in_valid & in_ready, and only in IDLE.
// A result is offered on out_valid and is released on out_ready.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of 4 and at least 4
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/bin valid
//   in_ready   block can accept operands (IDLE only)
//   a          minuend
//   b          subtrahend
//   bin        borrow-in
//   out_valid  result valid; diff/bout/ovf are stable while high
//   out_ready  sink accepts the result
//   diff       a - b - bin, modulo 2^WIDTH
//   bout       borrow-out: 1 iff unsigned a < b + bin
//   ovf        signed (two's-complement) overflow of the subtraction
// ----------------------------------------------------------------------------
module bla_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;
    // The slice index is kept at least one bit wide so that WIDTH=4 still elaborates.
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Operands are captured at accept time, so a and b may change freely after it.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_borrow;
    logic [IDX_W-1:0] r_idx;

    // Result registers. They are loaded only when an operation completes.
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_sa;
    logic [3:0]       w_sb;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_br;
    logic [3:0]       w_d;
    logic [WIDTH-1:0] w_work_new;
    logic             w_ovf_new;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: registers are updated with <= so that every flop samples values
    // from before the edge, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and handshake outputs. These are decoded from state only, so
    // no input reaches an output combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first. An output left unassigned
        // on some path would infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_idx == IDX_W'(NSLICE - 1));

    // ------------------------------------------------------------------------
    // Slice select: pick the 4-bit operand slice addressed by r_idx.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sa = 4'd0;
        w_sb = 4'd0;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_sa = r_a[4*s +: 4];
                w_sb = r_b[4*s +: 4];
            end
        end
    end

    // ------------------------------------------------------------------------
    // 4-bit borrow lookahead.
    // A bit generates a borrow when a_i=0 and b_i=1. It propagates the incoming
    // borrow when a_i==b_i. Every borrow is expanded directly from g/p and the
    // slice borrow-in, so borrows do not ripple through earlier bits.
    // ------------------------------------------------------------------------
    assign w_g = ~w_sa & w_sb;
    assign w_p = ~(w_sa ^ w_sb);

    assign w_br[0] = r_borrow;
    assign w_br[1] = w_g[0]
                   | (w_p[0] & r_borrow);
    assign w_br[2] = w_g[1]
                   | (w_p[1] & w_g[0])
                   | (w_p[1] & w_p[0] & r_borrow);
    assign w_br[3] = w_g[2]
                   | (w_p[2] & w_g[1])
                   | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_br[4] = w_g[3]
                   | (w_p[3] & w_g[2])
                   | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);

    assign w_d = w_sa ^ w_sb ^ w_br[3:0];

    // The working result with the current slice merged in. On the last slice
    // this is the complete difference, so diff and ovf are taken from it directly.
    always_comb begin
        w_work_new = r_work;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_work_new[4*s +: 4] = w_d;
            end
        end
    end

    // Overflow: the operands have different signs and the result sign differs from a.
    assign w_ovf_new = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_work_new[WIDTH-1]);

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_idx    <= '0;
                        r_work   <= '0;
                    end
                end
                S_CALC: begin
                    r_work   <= w_work_new;
                    r_borrow <= w_br[4];
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_diff <= w_work_new;
                        r_bout <= w_br[4];
                        r_ovf  <= w_ovf_new;
                    end
                end
                default: begin
                    // DONE: the result registers hold their values until the next completion.
                end
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bla_subtractor_seq.sv
// ----------------------------------------------------------------------------
// tb_bla_subtractor_seq
//
// Exercises a 16-bit instance and a 4-bit instance of bla_subtractor_seq.
// Expected results come from an arithmetic reference model. They are queued
// when an operand handshake happens and compared when a result is presented:
// on every held cycle and at the output handshake. Directed cases cover wrap,
// overflow, borrow-in, back-pressure, and reset in mid-calculation. Random
// traffic with random output stalls then runs on both widths.
// ----------------------------------------------------------------------------
module tb_bla_subtractor_seq;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, diff16;
    logic        bin16, bout16, ovf16;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, diff4;
    logic        bin4, bout4, ovf4;

    int   n_checks = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    exp_t q16[$];
    exp_t q4[$];
    logic acc16, acc4;
    logic prev_ov16, prev_ov4;
    logic rnd_ready;

    bla_subtractor_seq #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .bin       (bin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .diff      (diff16),
        .bout      (bout16),
        .ovf       (ovf16)
    );

    bla_subtractor_seq #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .bin       (bin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .diff      (diff4),
        .bout      (bout4),
        .ovf       (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: unsigned and signed arithmetic on w-bit operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin, input int w);
        exp_t   e;
        longint m, ua, ub, r, sa, sb, sr;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        r  = ua - ub - longint'(bin);
        e.bo = (r < 0);
        e.d  = 16'((r + m) % m);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = sa - sb - longint'(bin);
        e.ov  = (sr >= m / 2) || (sr < -(m / 2));
        e.acc = 0;
        return e;
    endfunction

    // Called on the falling edge: score outputs, then record newly accepted operands.
    task automatic sample();
        exp_t e;
        acc16 = 1'b0;
        acc4  = 1'b0;
        if (!rst_n) begin
            q16.delete();
            q4.delete();
            prev_ov16 = 1'b0;
            prev_ov4  = 1'b0;
            return;
        end

        if (out_valid16) begin
            if (q16.size() == 0) begin
                check("spurious16", 32'd1, 32'd0);
            end else begin
                e = q16[0];
                if (!prev_ov16) check("lat16", cyc - e.acc, 32'd4);
                if (out_ready16) begin
                    check("res16", {14'd0, ovf16, bout16, diff16}, {14'd0, e.ov, e.bo, e.d});
                    void'(q16.pop_front());
                end else begin
                    check("hold16", {14'd0, ovf16, bout16, diff16}, {14'd0, e.ov, e.bo, e.d});
                end
            end
        end
        prev_ov16 = out_valid16;
        if (in_valid16 && in_ready16) begin
            e     = model(a16, b16, bin16, 16);
            e.acc = cyc + 1;
            q16.push_back(e);
            acc16 = 1'b1;
        end

        if (out_valid4) begin
            if (q4.size() == 0) begin
                check("spurious4", 32'd1, 32'd0);
            end else begin
                e = q4[0];
                if (!prev_ov4) check("lat4", cyc - e.acc, 32'd1);
                if (out_ready4) begin
                    check("res4", {26'd0, ovf4, bout4, diff4}, {26'd0, e.ov, e.bo, e.d[3:0]});
                    void'(q4.pop_front());
                end else begin
                    check("hold4", {26'd0, ovf4, bout4, diff4}, {26'd0, e.ov, e.bo, e.d[3:0]});
                end
            end
        end
        prev_ov4 = out_valid4;
        if (in_valid4 && in_ready4) begin
            e     = model({12'd0, a4}, {12'd0, b4}, bin4, 4);
            e.acc = cyc + 1;
            q4.push_back(e);
            acc4 = 1'b1;
        end
    endtask

    // One clock: score on the falling edge, then return 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rnd_ready) begin
            out_ready16 = ($urandom_range(0, 3) != 0);
            out_ready4  = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int t;
        a16 = a;
        b16 = b;
        bin16 = bin;
        in_valid16 = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!acc16 && t < 100);
        if (!acc16) check("accept_timeout16", 32'd0, 32'd1);
        in_valid16 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int t;
        a4 = a;
        b4 = b;
        bin4 = bin;
        in_valid4 = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!acc4 && t < 100);
        if (!acc4) check("accept_timeout4", 32'd0, 32'd1);
        in_valid4 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q16.size() != 0 || q4.size() != 0 || out_valid16 || out_valid4) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n16, n4, t;
        localparam int NRAND = 2000;

        rst_n = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0; out_ready16 = 1'b1;
        in_valid4  = 1'b0; a4  = '0; b4  = '0; bin4  = 1'b0; out_ready4  = 1'b1;
        rnd_ready = 1'b0;
        acc16 = 1'b0; acc4 = 1'b0; prev_ov16 = 1'b0; prev_ov4 = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid16", out_valid16, 32'd0);
        check("rst_in_ready16", in_ready16, 32'd1);
        check("rst_result16", {ovf16, bout16, diff16}, 32'd0);
        check("rst_out_valid4", out_valid4, 32'd0);
        check("rst_in_ready4", in_ready4, 32'd1);
        check("rst_result4", {ovf4, bout4, diff4}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic, wrap, overflow and borrow-in cases
        issue16(16'h1234, 16'h0234, 1'b0); drain();
        issue16(16'h0000, 16'h0001, 1'b0); drain();
        issue16(16'h8000, 16'h0001, 1'b0); drain();
        issue16(16'h0005, 16'h0005, 1'b1); drain();
        issue16(16'hFFFF, 16'h0000, 1'b1); drain();
        issue4(4'h0, 4'h1, 1'b0); drain();
        issue4(4'h8, 4'h1, 1'b0); drain();
        issue4(4'h3, 4'h3, 1'b1); drain();

        // Back-pressure: DONE is held and extra operands are ignored
        out_ready16 = 1'b0;
        issue16(16'hABCD, 16'h1234, 1'b0);
        t = 0;
        while (!out_valid16 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("done_timeout16", 32'd0, 32'd1);
        repeat (6) tick();
        a16 = 16'h0F0F; b16 = 16'h7777; bin16 = 1'b1; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        check("stall_out_valid16", out_valid16, 32'd1);
        check("stall_in_ready16", in_ready16, 32'd0);
        check("stall_diff16", diff16, 32'h9999);
        tick();
        out_ready16 = 1'b1;
        tick();
        check("release_in_ready16", in_ready16, 32'd1);
        check("release_out_valid16", out_valid16, 32'd0);
        drain();

        // Reset during the second CALC cycle
        issue16(16'h5555, 16'h1111, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_diff16", diff16, 32'd0);
        check("midrst_bout16", bout16, 32'd0);
        check("midrst_out_valid16", out_valid16, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        issue16(16'h00FF, 16'h0100, 1'b0); drain();

        // Random traffic on both widths with random output stalls
        rnd_ready = 1'b1;
        n16 = 0;
        n4  = 0;
        t   = 0;
        while (!(n16 == NRAND && n4 == NRAND && q16.size() == 0 && q4.size() == 0) && t < 60000) begin
            if (!in_valid16 && n16 < NRAND) begin
                a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom_range(0, 1));
                in_valid16 = 1'b1;
            end
            if (!in_valid4 && n4 < NRAND) begin
                a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom_range(0, 1));
                in_valid4 = 1'b1;
            end
            tick();
            t++;
            if (acc16) begin in_valid16 = 1'b0; n16++; end
            if (acc4)  begin in_valid4  = 1'b0; n4++;  end
        end
        rnd_ready = 1'b0;
        out_ready16 = 1'b1;
        out_ready4  = 1'b1;
        check("rand_issued16", n16, NRAND);
        check("rand_issued4", n4, NRAND);
        drain();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
